// File: rtl/delay_pkg.sv
// Shared constants and the counter-width helper for the delay_match block.
package delay_pkg;

  localparam int unsigned DEFAULT_DEPTH      = 4;
  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/delay_match_fifo.sv
// Early-side (A) beat queue: storage, wrapping pointers, occupancy, full/empty.
module delay_match_fifo
  import delay_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_WIDTH-1:0]         wdata,
  output logic [DATA_WIDTH-1:0]         rdata_c,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic                          empty_c,
  output logic                          full_c
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;

  // Contents are don't-care after reset, so storage carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // A push at full only happens alongside a pop, so the head is read before being overwritten.
  assign rdata_c = mem[rd_ptr];
  assign empty_c = (count == '0);
  assign full_c  = (count == CW'(DEPTH));

endmodule

// File: rtl/delay_match.sv
// Joins early stream A with late stream B, absorbing up to DEPTH cycles of skew.
// Optional running-max occupancy output enabled by DELAY_MATCH_SKEW_STAT_EN.
module delay_match
  import delay_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        a_valid,
  input  logic [DATA_WIDTH-1:0]       a_data,
  input  logic                        b_valid,
  input  logic [DATA_WIDTH-1:0]       b_data,
  output logic                        out_valid,
  output logic [DATA_WIDTH-1:0]       out_a,
  output logic [DATA_WIDTH-1:0]       out_b,
  output logic [cnt_width(DEPTH)-1:0] pend_cnt,
  output logic                        overflow,
  output logic                        underflow
`ifdef DELAY_MATCH_SKEW_STAT_EN
  ,
  output logic [cnt_width(DEPTH)-1:0] max_skew
`endif
);

  logic [DATA_WIDTH-1:0] head_c;
  logic                  empty_c;
  logic                  full_c;
  logic                  bypass_c;
  logic                  pop_c;
  logic                  push_req_c;
  logic                  push_c;
  logic                  drop_c;
  logic                  under_c;

  // Pairing decisions; a clear cycle ignores all stream inputs.
  always_comb begin
    bypass_c   = 1'b0;
    pop_c      = 1'b0;
    push_req_c = 1'b0;
    push_c     = 1'b0;
    drop_c     = 1'b0;
    under_c    = 1'b0;
    if (!clear) begin
      bypass_c   = a_valid && b_valid && empty_c;
      pop_c      = b_valid && !empty_c;
      push_req_c = a_valid && !bypass_c;
      push_c     = push_req_c && (!full_c || pop_c);
      drop_c     = push_req_c && full_c && !pop_c;
      under_c    = b_valid && empty_c && !a_valid;
    end
  end

  delay_match_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .push    (push_c),
    .pop     (pop_c),
    .wdata   (a_data),
    .rdata_c (head_c),
    .count   (pend_cnt),
    .empty_c (empty_c),
    .full_c  (full_c)
  );

  // Joined-word register; data holds while no pair is produced.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      out_valid <= bypass_c || pop_c;
      if (bypass_c) begin
        out_a <= a_data;
        out_b <= b_data;
      end else if (pop_c) begin
        out_a <= head_c;
        out_b <= b_data;
      end
      if (drop_c) begin
        overflow <= 1'b1;
      end
      if (under_c) begin
        underflow <= 1'b1;
      end
    end
  end

`ifdef DELAY_MATCH_SKEW_STAT_EN
  // Running maximum of occupancy; survives clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      max_skew <= '0;
    end else if (pend_cnt > max_skew) begin
      max_skew <= pend_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_delay_match.sv
// Self-checking bench for delay_match: reference queue model plus pair scoreboard.
module tb_delay_match;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } pair_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clear = 1'b0;
  logic          a_valid = 1'b0;
  logic [DW-1:0] a_data = '0;
  logic          b_valid = 1'b0;
  logic [DW-1:0] b_data = '0;
  logic          out_valid;
  logic [DW-1:0] out_a;
  logic [DW-1:0] out_b;
  logic [CW-1:0] pend_cnt;
  logic          overflow;
  logic          underflow;
`ifdef DELAY_MATCH_SKEW_STAT_EN
  logic [CW-1:0] max_skew;
`endif

  delay_match #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .out_valid (out_valid),
    .out_a     (out_a),
    .out_b     (out_b),
    .pend_cnt  (pend_cnt),
    .overflow  (overflow),
    .underflow (underflow)
`ifdef DELAY_MATCH_SKEW_STAT_EN
    ,
    .max_skew  (max_skew)
`endif
  );

  always #5 clk = ~clk;

  pair_t         sb[$];
  logic [DW-1:0] mq[$];
  logic          exp_v;
  logic          m_over;
  logic          m_under;
  logic [DW-1:0] last_a;
  logic [DW-1:0] last_b;
  logic [CW-1:0] m_max;
  int            errors = 0;
  int            checks = 0;

  task automatic do_reset();
    reset = 1'b1;
    clear = 1'b0;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    mq.delete();
    sb.delete();
    exp_v   = 1'b0;
    m_over  = 1'b0;
    m_under = 1'b0;
    last_a  = '0;
    last_b  = '0;
    m_max   = '0;
  endtask

  // Drive one cycle and advance the reference model across the same edge.
  task automatic drive(input logic av, input logic [DW-1:0] ad,
                       input logic bv, input logic [DW-1:0] bd, input logic clr);
    pair_t pr;
    logic  bypassed;
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd; clear = clr;
    if (CW'(mq.size()) > m_max) m_max = CW'(mq.size());
    exp_v    = 1'b0;
    bypassed = 1'b0;
    if (clr) begin
      mq.delete();
    end else begin
      if (bv && mq.size() > 0) begin
        pr.a = mq.pop_front(); pr.b = bd;
        sb.push_back(pr); exp_v = 1'b1;
      end else if (bv && av) begin
        pr.a = ad; pr.b = bd;
        sb.push_back(pr); exp_v = 1'b1; bypassed = 1'b1;
      end else if (bv) begin
        m_under = 1'b1;
      end
      if (av && !bypassed) begin
        if (mq.size() < int'(DEPTH)) mq.push_back(ad);
        else m_over = 1'b1;
      end
      if (exp_v) begin
        last_a = pr.a; last_b = pr.b;
      end
    end
    @(posedge clk);
    #1;
    a_valid = 1'b0; b_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({out_valid, out_a, out_b, pend_cnt, overflow, underflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b a=%h b=%h cnt=%0d ovf=%0b unf=%0b, want all 0",
               out_valid, out_a, out_b, pend_cnt, overflow, underflow);
    end
`ifdef DELAY_MATCH_SKEW_STAT_EN
    checks++;
    if (max_skew !== '0) begin
      errors++;
      $display("FAIL reset_max_skew: got %0d want 0", max_skew);
    end
`endif
  endtask

  task automatic test_delayed();
    logic [CW-1:0] want_cnt[3] = '{3'd1, 3'd1, 3'd0};
    pair_t e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       drive(1'b1, 8'h11, 1'b0, 8'h00, 1'b0);
        2:       drive(1'b0, 8'h00, 1'b1, 8'h22, 1'b0);
        default: drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      endcase
      checks++;
      if (exp_v) begin
        e = sb.pop_front();
        if (out_valid !== 1'b1 || out_a !== e.a || out_b !== e.b || i != 2) begin
          errors++;
          $display("FAIL delayed_pair cyc%0d: got v=%0b a=%h b=%h want v=1 a=%h b=%h",
                   i, out_valid, out_a, out_b, e.a, e.b);
        end
      end else if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL delayed_idle cyc%0d: got out_valid=%0b want 0", i, out_valid);
      end
      if (i < 3) begin
        checks++;
        if (pend_cnt !== want_cnt[i]) begin
          errors++;
          $display("FAIL delayed_cnt cyc%0d: got %0d want %0d", i, pend_cnt, want_cnt[i]);
        end
      end
    end
  endtask

  task automatic test_bypass();
    pair_t e;
    do_reset();
    for (int n = 0; n < 8; n++) begin
      drive(1'b1, DW'(n), 1'b1, DW'(n + 8'h80), 1'b0);
      checks++;
      e = sb.pop_front();
      if (out_valid !== 1'b1 || out_a !== DW'(n) || out_b !== DW'(n + 8'h80) ||
          e.a !== DW'(n) || pend_cnt !== '0) begin
        errors++;
        $display("FAIL bypass n=%0d: got v=%0b a=%h b=%h cnt=%0d want v=1 a=%h b=%h cnt=0",
                 n, out_valid, out_a, out_b, pend_cnt, DW'(n), DW'(n + 8'h80));
      end
    end
  endtask

  task automatic test_full_simul();
    pair_t e;
    do_reset();
    for (int i = 1; i <= 4; i++) drive(1'b1, DW'(i), 1'b0, '0, 1'b0);
    drive(1'b1, 8'h09, 1'b1, 8'h33, 1'b0);
    checks++;
    e = sb.pop_front();
    if (out_valid !== 1'b1 || out_a !== 8'h01 || out_b !== 8'h33 || e.a !== 8'h01 ||
        pend_cnt !== 3'd4 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_simul: got v=%0b a=%h b=%h cnt=%0d ovf=%0b want v=1 a=01 b=33 cnt=4 ovf=0",
               out_valid, out_a, out_b, pend_cnt, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b1, DW'(8'hC0 + i), 1'b0);
      checks++;
      e = sb.pop_front();
      if (out_valid !== 1'b1 || out_a !== e.a || out_b !== e.b) begin
        errors++;
        $display("FAIL full_drain %0d: got v=%0b a=%h b=%h want a=%h b=%h",
                 i, out_valid, out_a, out_b, e.a, e.b);
      end
    end
    checks++;
    if (out_a !== 8'h09) begin
      errors++;
      $display("FAIL full_last_a: got %h want 09", out_a);
    end
  endtask

  task automatic test_overflow();
    pair_t e;
    do_reset();
    for (int i = 1; i <= 5; i++) drive(1'b1, DW'(i), 1'b0, '0, 1'b0);
    checks++;
    if (pend_cnt !== 3'd4 || overflow !== 1'b1 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_flag: got cnt=%0d ovf=%0b unf=%0b want cnt=4 ovf=1 unf=0",
               pend_cnt, overflow, underflow);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b1, DW'(8'hA0 + i), 1'b0);
      checks++;
      e = sb.pop_front();
      if (out_valid !== 1'b1 || out_a !== DW'(i + 1) || out_b !== DW'(8'hA0 + i) || e.a !== DW'(i + 1)) begin
        errors++;
        $display("FAIL overflow_drain %0d: got v=%0b a=%h b=%h want v=1 a=%h b=%h",
                 i, out_valid, out_a, out_b, DW'(i + 1), DW'(8'hA0 + i));
      end
    end
    checks++;
    if (pend_cnt !== '0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_end: got cnt=%0d ovf=%0b want cnt=0 ovf=1", pend_cnt, overflow);
    end
  endtask

  task automatic test_underflow();
    pair_t e;
    do_reset();
    drive(1'b0, '0, 1'b1, 8'h44, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || underflow !== 1'b1 || pend_cnt !== '0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL underflow_flag: got v=%0b unf=%0b cnt=%0d ovf=%0b want v=0 unf=1 cnt=0 ovf=0",
               out_valid, underflow, pend_cnt, overflow);
    end
    drive(1'b1, 8'h55, 1'b1, 8'h66, 1'b0);
    checks++;
    e = sb.pop_front();
    if (out_valid !== 1'b1 || out_a !== 8'h55 || out_b !== 8'h66 || e.b !== 8'h66 || underflow !== 1'b1) begin
      errors++;
      $display("FAIL underflow_recover: got v=%0b a=%h b=%h unf=%0b want v=1 a=55 b=66 unf=1",
               out_valid, out_a, out_b, underflow);
    end
  endtask

  task automatic test_clear_and_reset();
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, DW'(8'h30 + i), 1'b0, '0, 1'b0);
    drive(1'b1, 8'hEE, 1'b1, 8'hDD, 1'b1);
    checks++;
    if (pend_cnt !== '0 || out_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL clear_flush: got cnt=%0d v=%0b ovf=%0b unf=%0b want 0 0 0 0",
               pend_cnt, out_valid, overflow, underflow);
    end
    drive(1'b0, '0, 1'b1, 8'h12, 1'b0);
    checks++;
    if (underflow !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_then_b: got unf=%0b v=%0b want unf=1 v=0", underflow, out_valid);
    end
    drive(1'b1, 8'h41, 1'b0, '0, 1'b0);
    drive(1'b1, 8'h42, 1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b1, 8'h77, 1'b0);
    void'(sb.pop_front());
    a_valid = 1'b1; a_data = 8'h43; b_valid = 1'b1; b_data = 8'h78;
    do_reset();
    checks++;
    if ({out_valid, out_a, out_b, pend_cnt, overflow, underflow} !== '0) begin
      errors++;
      $display("FAIL midstream_reset: got v=%0b a=%h b=%h cnt=%0d ovf=%0b unf=%0b want all 0",
               out_valid, out_a, out_b, pend_cnt, overflow, underflow);
    end
  endtask

  task automatic test_random();
    pair_t e;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 6), DW'($urandom), ($urandom_range(0, 9) < 5), DW'($urandom),
            ($urandom_range(0, 39) == 0));
      checks++;
      if (exp_v) begin
        e = sb.pop_front();
        if (out_valid !== 1'b1 || out_a !== e.a || out_b !== e.b) begin
          errors++;
          $display("FAIL random_pair cyc%0d: got v=%0b a=%h b=%h want v=1 a=%h b=%h",
                   i, out_valid, out_a, out_b, e.a, e.b);
        end
      end else if (out_valid !== 1'b0 || out_a !== last_a || out_b !== last_b) begin
        errors++;
        $display("FAIL random_hold cyc%0d: got v=%0b a=%h b=%h want v=0 a=%h b=%h",
                 i, out_valid, out_a, out_b, last_a, last_b);
      end
      checks++;
      if (pend_cnt !== CW'(mq.size()) || overflow !== m_over || underflow !== m_under) begin
        errors++;
        $display("FAIL random_state cyc%0d: got cnt=%0d ovf=%0b unf=%0b want cnt=%0d ovf=%0b unf=%0b",
                 i, pend_cnt, overflow, underflow, mq.size(), m_over, m_under);
      end
`ifdef DELAY_MATCH_SKEW_STAT_EN
      checks++;
      if (max_skew !== m_max) begin
        errors++;
        $display("FAIL random_max_skew cyc%0d: got %0d want %0d", i, max_skew, m_max);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_delayed();
    test_bypass();
    test_full_simul();
    test_overflow();
    test_underflow();
    test_clear_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
